// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state encoding and ALU function codes for the operand loader.
package alu_pkg;
  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_LOAD_F = 3'd2,
    S_EXEC   = 3'd3,
    S_SHOW   = 3'd4
  } alu_load_state_t;
  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_OR  = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_CAT = 3'd3;
endpackage

// File: rtl/alu_operand_loader_if.sv
// alu_operand_loader_if: button/switch inputs, ALU feedback and registered outputs of the loader.
interface alu_operand_loader_if #(parameter int N = 4);
  logic           load;
  logic           clear;
  logic [N-1:0]   data_in;
  logic [2:0]     func_in;
  logic [2*N-1:0] alu_result;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2:0]     Function;
  logic [2*N-1:0] result;
  logic           result_valid;
  logic [2:0]     stage;
  modport master (
    output load, clear, data_in, func_in, alu_result,
    input  A, B, Function, result, result_valid, stage
  );
  modport slave (
    input  load, clear, data_in, func_in, alu_result,
    output A, B, Function, result, result_valid, stage
  );
endinterface

// File: rtl/alu_operand_loader_rise_detect.sv
// rise_detect: one-cycle pulse on a rising input; resets high so a level held through reset gives no pulse.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic d_q;
  logic d_d;
  always_comb d_d = d;
  always_ff @(posedge clk)
    if (reset) d_q <= 1'b1;
    else d_q <= d_d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: sequences A, B and function code from one load button and registers the ALU result.
// Optional: define ALU_CHAIN_EN so a press in S_SHOW chains the result into A and loads a new B.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input logic              clk,
  input logic              reset,
  alu_operand_loader_if.slave bus
);
  alu_load_state_t state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [2:0]      f_q, f_d;
  logic [2*N-1:0]  res_q, res_d;
  logic            load_rise;
  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .d     (bus.load),
    .rise  (load_rise)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    res_d   = res_q;
    if (bus.clear) begin
      state_d = S_LOAD_A;
      a_d     = '0;
      b_d     = '0;
      f_d     = '0;
      res_d   = '0;
    end else begin
      case (state_q)
        S_LOAD_A: if (load_rise) begin a_d = bus.data_in; state_d = S_LOAD_B; end
        S_LOAD_B: if (load_rise) begin b_d = bus.data_in; state_d = S_LOAD_F; end
        S_LOAD_F: if (load_rise) begin f_d = bus.func_in; state_d = S_EXEC; end
        S_EXEC: begin
          res_d   = bus.alu_result;
          state_d = S_SHOW;
        end
        S_SHOW: if (load_rise) begin
`ifdef ALU_CHAIN_EN
          a_d     = res_q[N-1:0];
          b_d     = bus.data_in;
          state_d = S_LOAD_F;
`else
          state_d = S_LOAD_A;
`endif
        end
        default: state_d = S_LOAD_A;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= S_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      res_q   <= res_d;
    end
  assign bus.A            = a_q;
  assign bus.B            = b_q;
  assign bus.Function     = f_q;
  assign bus.result       = res_q;
  assign bus.result_valid = (state_q == S_SHOW);
  assign bus.stage        = state_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed checks of operand sequencing, edge detect, clear, reset and result capture.
module tb_alu_operand_loader;
  import alu_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  alu_operand_loader_if #(.N(N)) bus ();
  alu_operand_loader #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  // stands in for param_ALU: combinational result from the registered operands
  always_comb begin
    bus.alu_result = '0;
    case (bus.Function)
      FN_ADD: bus.alu_result = (2*N)'(bus.A) + (2*N)'(bus.B);
      FN_OR:  bus.alu_result = (2*N)'(bus.A | bus.B);
      FN_AND: bus.alu_result = (2*N)'(bus.A & bus.B);
      FN_CAT: bus.alu_result = {bus.A, bus.B};
      default: bus.alu_result = '0;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [N-1:0] d, input logic [2:0] f);
    bus.data_in = d;
    bus.func_in = f;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
  endtask
  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.load = 1'b0;
    bus.clear = 1'b0;
    bus.data_in = '0;
    bus.func_in = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_stage", 32'(bus.stage), 0);
    chk("rst_A", 32'(bus.A), 0);
    chk("rst_B", 32'(bus.B), 0);
    chk("rst_F", 32'(bus.Function), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_valid", 32'(bus.result_valid), 0);
    // test 1: 3 + 5 with explicit latency checks
    press(4'd3, FN_ADD);
    press(4'd5, FN_ADD);
    chk("t1_stage_f", 32'(bus.stage), 2);
    bus.func_in = FN_ADD;
    bus.load = 1'b1;
    tick();
    chk("t1_k1_stage", 32'(bus.stage), 3);
    chk("t1_k1_valid", 32'(bus.result_valid), 0);
    chk("t1_k1_result", 32'(bus.result), 0);
    bus.load = 1'b0;
    tick();
    chk("t1_result", 32'(bus.result), 32'h08);
    chk("t1_valid", 32'(bus.result_valid), 1);
    chk("t1_stage_show", 32'(bus.stage), 4);
    repeat (3) tick();
    chk("t1_show_hold", 32'(bus.stage), 4);
`ifdef ALU_CHAIN_EN
    press(4'd1, FN_ADD);
    chk("t6_A", 32'(bus.A), 8);
    chk("t6_B", 32'(bus.B), 1);
    chk("t6_stage", 32'(bus.stage), 2);
    press(4'd0, FN_ADD);
    chk("t6_result", 32'(bus.result), 32'h09);
    do_clear();
    tick();
`else
    press(4'd0, FN_ADD);
    chk("t1_back_stage", 32'(bus.stage), 0);
    chk("t1_back_valid", 32'(bus.result_valid), 0);
`endif
    // test 2: concatenation
    press(4'hA, FN_ADD);
    press(4'h5, FN_ADD);
    press(4'h0, FN_CAT);
    chk("t2_result", 32'(bus.result), 32'hA5);
    chk("t2_valid", 32'(bus.result_valid), 1);
    press(4'h3, FN_ADD);
`ifdef ALU_CHAIN_EN
    chk("t2_chain_stage", 32'(bus.stage), 2);
    chk("t2_chain_A", 32'(bus.A), 5);
    chk("t2_chain_B", 32'(bus.B), 3);
`else
    chk("t2_stage", 32'(bus.stage), 0);
    chk("t2_keep_result", 32'(bus.result), 32'hA5);
    chk("t2_valid_low", 32'(bus.result_valid), 0);
    chk("t2_keep_A", 32'(bus.A), 4'hA);
`endif
    do_clear();
    chk("clr_result", 32'(bus.result), 0);
    chk("clr_stage", 32'(bus.stage), 0);
    // test 3: long hold gives a single advance
    bus.data_in = 4'd7;
    bus.load = 1'b1;
    repeat (10) tick();
    chk("t3_A", 32'(bus.A), 7);
    chk("t3_stage", 32'(bus.stage), 1);
    chk("t3_B", 32'(bus.B), 0);
    bus.load = 1'b0;
    tick();
    chk("t3_stage_after", 32'(bus.stage), 1);
    // test 4: clear beats a simultaneous load edge in S_LOAD_F
    do_clear();
    press(4'd3, FN_ADD);
    press(4'd5, FN_ADD);
    bus.func_in = FN_CAT;
    bus.load = 1'b1;
    bus.clear = 1'b1;
    tick();
    chk("t4_stage", 32'(bus.stage), 0);
    chk("t4_A", 32'(bus.A), 0);
    chk("t4_B", 32'(bus.B), 0);
    chk("t4_F", 32'(bus.Function), 0);
    bus.load = 1'b0;
    bus.clear = 1'b0;
    tick();
    // clear in S_EXEC suppresses the capture
    press(4'd1, FN_ADD);
    press(4'd2, FN_ADD);
    bus.func_in = FN_ADD;
    bus.load = 1'b1;
    tick();
    chk("exec_stage", 32'(bus.stage), 3);
    bus.load = 1'b0;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("exec_clr_result", 32'(bus.result), 0);
    chk("exec_clr_stage", 32'(bus.stage), 0);
    // remaining function codes, including a reserved one
    press(4'd6, FN_ADD);
    press(4'd3, FN_ADD);
    press(4'd0, FN_OR);
    chk("or_result", 32'(bus.result), 32'h07);
    do_clear();
    press(4'd6, FN_ADD);
    press(4'd3, FN_ADD);
    press(4'd0, FN_AND);
    chk("and_result", 32'(bus.result), 32'h02);
    do_clear();
    press(4'hF, FN_ADD);
    press(4'hF, FN_ADD);
    press(4'd0, FN_ADD);
    chk("add_max", 32'(bus.result), 32'h1E);
    do_clear();
    press(4'hF, FN_ADD);
    press(4'hF, FN_ADD);
    press(4'd0, FN_CAT);
    chk("cat_max", 32'(bus.result), 32'hFF);
    do_clear();
    press(4'd6, FN_ADD);
    press(4'd3, FN_ADD);
    press(4'd0, 3'd6);
    chk("rsv_F", 32'(bus.Function), 6);
    chk("rsv_result", 32'(bus.result), 0);
    chk("rsv_valid", 32'(bus.result_valid), 1);
    // test 5: load held through reset release
    bus.load = 1'b1;
    bus.data_in = 4'd9;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("t5_stage", 32'(bus.stage), 0);
    chk("t5_A_hold", 32'(bus.A), 0);
    chk("t5_result", 32'(bus.result), 0);
    bus.load = 1'b0;
    tick();
    press(4'd2, FN_ADD);
    chk("t5_A", 32'(bus.A), 2);
    chk("t5_stage_b", 32'(bus.stage), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
